sevenseg_poll_out: RTL and testbench

Polled output peripheral: the CPU-to-user counterpart of the polled switch-bank input. The CPU writes a 16-bit word into a one-entry pending buffer and polls a status register. The user presses a key to accept the word, which moves it to a 4-digit multiplexed hex seven-segment display and frees the buffer. It sits on the same a0-decoded, two-register I/O bus as the switch bank.

---
 rtl/sevenseg_pkg.sv | 19 +
 rtl/hex_to_7seg.sv | 11 +
 rtl/sevenseg_poll_out.sv | 99 +++++++++
 tb/tb_sevenseg_poll_out.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the polled seven-segment output peripheral:
// status/control bit positions, key idle level and the hex glyph table.
package sevenseg_pkg;

  localparam int STATUS_FULL_BIT    = 0;
  localparam int STATUS_OVERRUN_BIT = 1;
  localparam int CTRL_CLR_OVR_BIT   = 1;

  localparam logic [1:0] KEY_IDLE = 2'b11;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sevenseg_poll_out.sv
// Polled CPU output port: one-entry pending buffer released by a user key
// onto a 4-digit multiplexed hex seven-segment display.
module sevenseg_poll_out
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a0,
  input  logic        wr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        next_key,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]      pending_reg;
  logic [15:0]      display_reg;
  logic             full;
  logic             overrun;
  logic [1:0]       key_sync;
  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit;

  logic        data_wr;
  logic        ctrl_wr;
  logic        accept;
  logic [15:0] status;
  logic [3:0]  nibble;

  // Handshake: the CPU offers a word by a data write (wr & ~a0) while full==0;
  // the user takes it with one falling key edge while full==1, which clears full.
  assign data_wr = wr & ~a0;
  assign ctrl_wr = wr & a0;
  assign accept  = (key_sync == 2'b10);

  always_comb begin
    status = '0;
    status[STATUS_FULL_BIT]    = full;
    status[STATUS_OVERRUN_BIT] = overrun;
  end

  assign data_out = a0 ? status : display_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      display_reg <= '0;
      full        <= 1'b0;
      overrun     <= 1'b0;
      key_sync    <= KEY_IDLE;
      refresh_cnt <= '0;
      digit       <= '0;
    end else begin
      key_sync <= {key_sync[0], next_key};

      if (accept && full) begin
        display_reg <= pending_reg;
      end

      // A write while full only lands if the same edge drains the old word.
      if (data_wr) begin
        if (!full || accept) begin
          pending_reg <= data_in;
          full        <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept && full) begin
        full <= 1'b0;
      end

      if (ctrl_wr && data_in[CTRL_CLR_OVR_BIT]) begin
        overrun <= 1'b0;
      end

      if (refresh_cnt == CNT_LAST) begin
        refresh_cnt <= '0;
        digit       <= digit + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  assign nibble = display_reg[{digit, 2'b00} +: 4];
  assign an     = ~(4'b0001 << digit);

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble),
    .seg    (seg)
  );

endmodule

// File: tb/tb_sevenseg_poll_out.sv
// Bench for sevenseg_poll_out: directed vector table, hand sequences for key
// hold / reset corners, and randomized traffic against a behavioural model.
module tb_sevenseg_poll_out;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a0 = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        next_key = 1'b1;
  logic [3:0]  an;
  logic [6:0]  seg;

  always #5 clk = ~clk;

  sevenseg_poll_out #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .a0       (a0),
    .wr       (wr),
    .data_in  (data_in),
    .data_out (data_out),
    .next_key (next_key),
    .an       (an),
    .seg      (seg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [15:0] m_pend, m_disp;
  logic        m_full, m_ovr;
  logic        key_hist[$];
  int          m_cyc;

  logic [6:0] hex_pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [15:0] last_disp, last_stat;

  typedef struct {
    logic        r, w, a;
    logic [15:0] d;
    logic        k;
    logic [15:0] st;
    logic [15:0] disp;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept fires one edge after the key is first seen low following a high sample.
  task automatic model_edge(input logic r, input logic w, input logic a,
                            input logic [15:0] d, input logic k);
    logic acc;
    if (r) begin
      m_pend = '0; m_disp = '0; m_full = 1'b0; m_ovr = 1'b0; m_cyc = 0;
      key_hist.delete();
      key_hist.push_back(1'b1);
      key_hist.push_back(1'b1);
      return;
    end
    acc = key_hist[key_hist.size()-2] && !key_hist[key_hist.size()-1];
    key_hist.push_back(k);
    if (key_hist.size() > 4) void'(key_hist.pop_front());
    m_cyc++;
    if (w && !a) begin
      if (!m_full) begin
        m_pend = d; m_full = 1'b1;
      end else if (acc) begin
        m_disp = m_pend; m_pend = d;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (acc && m_full) begin
      m_disp = m_pend; m_full = 1'b0;
    end
    if (w && a && d[1]) m_ovr = 1'b0;
  endtask

  task automatic cycle(input logic r, input logic w, input logic a,
                       input logic [15:0] d, input logic k, input string tag);
    int dig;
    logic [3:0] e_an;
    rst = r; wr = w; a0 = a; data_in = d; next_key = k;
    @(posedge clk);
    model_edge(r, w, a, d, k);
    #1;
    rst = 1'b0; wr = 1'b0;
    a0 = 1'b0; #1;
    last_disp = data_out;
    check({tag, " disp"}, data_out, m_disp);
    a0 = 1'b1; #1;
    last_stat = data_out;
    check({tag, " status"}, data_out, {14'b0, m_ovr, m_full});
    dig = (m_cyc / DIV) % 4;
    e_an = 4'b1111;
    e_an[dig] = 1'b0;
    check({tag, " an"}, {12'b0, an}, {12'b0, e_an});
    check({tag, " seg"}, {9'b0, seg}, {9'b0, hex_pat[(m_disp >> (4*dig)) & 16'hF]});
  endtask

  vec_t vt[$];

  initial begin
    logic [3:0] an_tbl [4];
    logic [6:0] seg_12ab [4];
    int d;

    // rst, wr, a0, data, key, expected status, expected display
    vt.push_back('{1, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000});
    vt.push_back('{0, 1, 0, 16'h12AB, 1, 16'h0001, 16'h0000});
    vt.push_back('{0, 0, 0, 16'h0000, 0, 16'h0001, 16'h0000});
    vt.push_back('{0, 0, 0, 16'h0000, 1, 16'h0000, 16'h12AB});
    vt.push_back('{0, 1, 0, 16'h1111, 1, 16'h0001, 16'h12AB});
    vt.push_back('{0, 1, 0, 16'h2222, 1, 16'h0003, 16'h12AB});
    vt.push_back('{0, 0, 0, 16'h0000, 0, 16'h0003, 16'h12AB});
    vt.push_back('{0, 0, 0, 16'h0000, 1, 16'h0002, 16'h1111});
    vt.push_back('{0, 1, 1, 16'h0002, 1, 16'h0000, 16'h1111});
    vt.push_back('{0, 1, 0, 16'hAAAA, 1, 16'h0001, 16'h1111});
    vt.push_back('{0, 0, 0, 16'h0000, 0, 16'h0001, 16'h1111});
    vt.push_back('{0, 1, 0, 16'h5555, 1, 16'h0001, 16'hAAAA});
    vt.push_back('{0, 0, 0, 16'h0000, 0, 16'h0001, 16'hAAAA});
    vt.push_back('{0, 0, 0, 16'h0000, 1, 16'h0000, 16'h5555});
    vt.push_back('{0, 0, 0, 16'h0000, 0, 16'h0000, 16'h5555});
    vt.push_back('{0, 1, 0, 16'h3333, 1, 16'h0001, 16'h5555});
    vt.push_back('{0, 0, 0, 16'h0000, 1, 16'h0001, 16'h5555});

    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].k, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_status", i), last_stat, vt[i].st);
      check($sformatf("vec%0d tbl_disp", i), last_disp, vt[i].disp);
      if (i == 0) begin
        check("reset an", {12'b0, an}, 16'h000E);
        check("reset seg", {9'b0, seg}, 16'h0040);
      end
    end

    // Holding the key low for 100 cycles transfers exactly once.
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, (i == 20), 1'b0, 16'h7777, 1'b0, "hold");
    end
    check("hold status", last_stat, 16'h0001);
    check("hold disp", last_disp, 16'h3333);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "release");
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "repress");
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "repress2");
    check("repress disp", last_disp, 16'h7777);
    check("repress status", last_stat, 16'h0000);

    // Digit scan of 0x12AB from a fresh reset.
    an_tbl   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_12ab = '{7'b0000011, 7'b0001000, 7'b0100100, 7'b1111001};
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, "scan_rst");
    cycle(1'b0, 1'b1, 1'b0, 16'h12AB, 1'b1, "scan_wr");
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "scan_k0");
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "scan_k1");
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "scan");
      d = ((i / DIV) + 1) % 4;
      check($sformatf("scan%0d an", i), {12'b0, an}, {12'b0, an_tbl[d]});
      check($sformatf("scan%0d seg", i), {9'b0, seg}, {9'b0, seg_12ab[d]});
    end

    // Reset mid-scan with full and overrun set, key held low across it.
    cycle(1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, "pre_rst_w1");
    cycle(1'b0, 1'b1, 1'b0, 16'h4321, 1'b1, "pre_rst_w2");
    check("pre_rst status", last_stat, 16'h0003);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "pre_rst_key");
    cycle(1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b0, "mid_rst");
    check("mid_rst status", last_stat, 16'h0000);
    check("mid_rst disp", last_disp, 16'h0000);
    check("mid_rst an", {12'b0, an}, 16'h000E);
    check("mid_rst seg", {9'b0, seg}, 16'h0040);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "post_rst0");
    cycle(1'b0, 1'b1, 1'b0, 16'h9999, 1'b0, "post_rst_wr");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "post_rst_hold");
    check("post_rst status", last_stat, 16'h0001);
    check("post_rst disp", last_disp, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, "post_rst_rel");
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "post_rst_press");
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, "post_rst_take");
    check("post_rst take disp", last_disp, 16'h9999);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic r, w, a, k;
      logic [15:0] dd;
      r  = ($urandom_range(0, 99) < 2);
      w  = ($urandom_range(0, 99) < 30);
      a  = ($urandom_range(0, 3) == 0);
      dd = 16'($urandom);
      k  = ($urandom_range(0, 99) < 70);
      cycle(r, w, a, dd, k, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
